// File: rtl/pulp_pwr_pkg.sv
// Purpose : shared types, default timings and output decode for the power-domain sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   pwr_state_e  - the eight sequencer states
//   pwr_outs_t   - bundle of the registered control outputs
//   pwr_decode() - per-state output levels (used on the next state so outputs are registered)
//   pwr_max3()   - helper used to size the step counter
package pulp_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_PU_SWITCH  = 3'd1,
    ST_PU_SETTLE  = 3'd2,
    ST_PU_UNCLAMP = 3'd3,
    ST_ON         = 3'd4,
    ST_PD_ISO     = 3'd5,
    ST_PD_CLAMP   = 3'd6,
    ST_PD_SWITCH  = 3'd7
  } pwr_state_e;

  // Default sequencing timings, in core clock cycles.
  localparam int unsigned PWR_ISO_SETUP_CYCLES = 4;
  localparam int unsigned PWR_SETTLE_CYCLES    = 16;
  localparam int unsigned PWR_ACK_TIMEOUT      = 256;

  typedef struct packed {
    logic sleep;    // 1 = switch chain off
    logic clamp;    // 1 = level shifters clamped to 0
    logic iso_ena;  // 1 = isolation cells pass
    logic pwr_ack;  // 1 = domain fully on
    logic busy;     // 1 = in a transitional state
  } pwr_outs_t;

  function automatic int unsigned pwr_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Output levels for each state. Every state keeps the invariants
  // iso_ena -> !clamp && !sleep and sleep -> clamp && !iso_ena.
  function automatic pwr_outs_t pwr_decode(input pwr_state_e s);
    pwr_outs_t o;
    o = '{sleep: 1'b1, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b0};
    case (s)
      ST_OFF:        o = '{sleep: 1'b1, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b0};
      ST_PU_SWITCH:  o = '{sleep: 1'b0, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      ST_PU_SETTLE:  o = '{sleep: 1'b0, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      ST_PU_UNCLAMP: o = '{sleep: 1'b0, clamp: 1'b0, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      ST_ON:         o = '{sleep: 1'b0, clamp: 1'b0, iso_ena: 1'b1, pwr_ack: 1'b1, busy: 1'b0};
      ST_PD_ISO:     o = '{sleep: 1'b0, clamp: 1'b0, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      ST_PD_CLAMP:   o = '{sleep: 1'b0, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      ST_PD_SWITCH:  o = '{sleep: 1'b1, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b1};
      default:       o = '{sleep: 1'b1, clamp: 1'b1, iso_ena: 1'b0, pwr_ack: 1'b0, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pulp_pwr_sync.sv
// Purpose : two-flop synchroniser for an asynchronous level into clk_i.
// Latency : 2 cycles from a stable input level to q_o.
// Backpressure: none (free-running level path).
//
// Ports:
//   clk_i  in  clock of the receiving domain
//   rst_i  in  synchronous reset, active-high; both flops load RST_VAL
//   d_i    in  asynchronous level
//   q_o    out synchronised level
module pulp_pwr_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/pulp_pwr_domain_ctrl.sv
// Purpose : sequences isolation, clamps and power switches of one switchable domain.
// Latency : outputs registered from next state; OFF->ON and ON->OFF take several
//           tens of cycles, set by the timing parameters and the switch-chain ack.
// Backpressure: none; pwr_req_i is a level sampled only in OFF/ON, so a request
//           that changes mid-sequence is honoured once the sequence completes.
//
// Ports:
//   clk_i       in  always-on clock
//   rst_i       in  synchronous reset, active-high (forces OFF on that edge)
//   pwr_req_i   in  1 = domain wanted on, 0 = wanted off
//   pwr_ack_o   out 1 only while fully on
//   busy_o      out 1 during any power-up/power-down step
//   iso_ena_o   out isolation enable, 1 = pass
//   clamp_o     out level-shifter clamp, 1 = clamped to 0
//   sleep_o     out switch-chain control, 1 = domain off
//   sleepout_i  in  switch-chain daisy output (asynchronous)
//   err_o       out sticky switch-ack timeout flag
//   err_clr_i   in  single-cycle clear of err_o
module pulp_pwr_domain_ctrl
  import pulp_pwr_pkg::*;
#(
  parameter int unsigned ISO_SETUP_CYCLES = PWR_ISO_SETUP_CYCLES,
  parameter int unsigned SETTLE_CYCLES    = PWR_SETTLE_CYCLES,
  parameter int unsigned ACK_TIMEOUT      = PWR_ACK_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_req_i,
  output logic pwr_ack_o,
  output logic busy_o,
  output logic iso_ena_o,
  output logic clamp_o,
  output logic sleep_o,
  input  logic sleepout_i,
  output logic err_o,
  input  logic err_clr_i
);

  localparam int unsigned CNT_MAX_CYC = pwr_max3(ISO_SETUP_CYCLES, SETTLE_CYCLES, ACK_TIMEOUT);
  localparam int unsigned CNT_W       = $clog2(CNT_MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  pwr_state_e       r_state;
  pwr_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  logic             w_sleepout_s;
  pwr_outs_t        r_outs;
  pwr_outs_t        w_outs_nxt;
  logic             r_err;

  // Chain output idles high while the domain is off, so the synchroniser
  // resets to 1 to avoid a spurious "switched on" indication after reset.
  pulp_pwr_sync #(
    .RST_VAL (1'b1)
  ) u_sleepout_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sleepout_i),
    .q_o   (w_sleepout_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A missing switch ack does not hang the sequence: after
  // ACK_TIMEOUT cycles it proceeds anyway and raises the sticky error.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (pwr_req_i) w_state_nxt = ST_PU_SWITCH;
      end
      ST_PU_SWITCH: begin
        if (!w_sleepout_s) begin
          w_state_nxt = ST_PU_SETTLE;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = ST_PU_SETTLE;
          w_timeout   = 1'b1;
        end
      end
      ST_PU_SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_state_nxt = ST_PU_UNCLAMP;
      end
      ST_PU_UNCLAMP: begin
        if (r_cnt == ISO_LAST) w_state_nxt = ST_ON;
      end
      ST_ON: begin
        if (!pwr_req_i) w_state_nxt = ST_PD_ISO;
      end
      ST_PD_ISO: begin
        if (r_cnt == ISO_LAST) w_state_nxt = ST_PD_CLAMP;
      end
      ST_PD_CLAMP: begin
        w_state_nxt = ST_PD_SWITCH;
      end
      ST_PD_SWITCH: begin
        if (w_sleepout_s) begin
          w_state_nxt = ST_OFF;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = ST_OFF;
          w_timeout   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // Step counter: restarts on every state change, saturates rather than wraps
  // so long dwell in OFF/ON can never alias onto a step boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so each control
  // changes exactly on the edge that enters its state and never glitches.
  always_comb begin
    w_outs_nxt = pwr_decode(w_state_nxt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outs <= pwr_decode(ST_OFF);
    end else begin
      r_outs <= w_outs_nxt;
    end
  end

  // Sticky timeout flag; a coincident set beats the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign sleep_o   = r_outs.sleep;
  assign clamp_o   = r_outs.clamp;
  assign iso_ena_o = r_outs.iso_ena;
  assign pwr_ack_o = r_outs.pwr_ack;
  assign busy_o    = r_outs.busy;
  assign err_o     = r_err;

endmodule
